// File: rtl/rob_commit_pkg.sv
// Shared payload types for the reorder buffer: dispatched instruction info
// and the per-entry view presented to the regfile / commit checker.
package rob_commit_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } pci_t;

  typedef struct packed {
    logic        rdy;
    pci_t        pc_info;
    logic [31:0] data;
  } sal2_t;

endpackage

// File: rtl/rob_commit.sv
// Reorder buffer: allocates entries in dispatch order, captures results by
// tag, retires up to COMMIT_WIDTH consecutive ready entries per cycle.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int unsigned size         = 8,
  parameter int unsigned COMMIT_WIDTH = 4,
  parameter int unsigned NUM_WB       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq,
  input  pci_t                    enq_pci,
  output logic [$clog2(size)-1:0] enq_tag,
  output logic                    full,
  output logic                    empty,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [$clog2(size)-1:0] wb_tag [NUM_WB],
  input  logic [31:0]             wb_data [NUM_WB],
  input  logic                    br_mispredict,
  input  logic [$clog2(size)-1:0] br_tag,
  output logic                    commit,
  output int                      num_deq,
  output logic [$clog2(size)-1:0] front_tag,
  output sal2_t                   rdest [size]
);

  localparam int unsigned TW = $clog2(size);
  localparam int unsigned CW = TW + 1;

  typedef logic [TW-1:0] tag_t;
  typedef logic [CW-1:0] cnt_t;

  tag_t            front_q, front_d;
  tag_t            rear_q, rear_d;
  cnt_t            count_q, count_d;
  logic [size-1:0] valid_q, valid_d;
  logic [size-1:0] ready_q, ready_d;
  logic [31:0]     data_q [size];
  logic [31:0]     data_d [size];
  pci_t            pci_q [size];
  pci_t            pci_d [size];

  cnt_t            n_deq;
  tag_t            sel_idx;
  logic            sel_stop;
  tag_t            br_age;
  logic            enq_ok;
  logic [size-1:0] flushed;

  // Leading run of ready entries from the head, capped by width and count
  always_comb begin
    n_deq    = '0;
    sel_idx  = '0;
    sel_stop = 1'b0;
    for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
      sel_idx = front_q + TW'(k);
      if (!sel_stop && (CW'(k) < count_q) && valid_q[sel_idx] && ready_q[sel_idx]) begin
        n_deq = n_deq + CW'(1);
      end else begin
        sel_stop = 1'b1;
      end
    end
  end

  always_comb begin
    front_d = front_q;
    rear_d  = rear_q;
    count_d = count_q;
    valid_d = valid_q;
    ready_d = ready_q;
    data_d  = data_q;
    pci_d   = pci_q;
    flushed = '0;
    br_age  = br_tag - front_q;
    enq_ok  = enq && !full && !br_mispredict;

    // Entries strictly younger than the mispredicted branch
    if (br_mispredict) begin
      for (int i = 0; i < int'(size); i++) begin
        if (valid_q[i] && ((TW'(i) - front_q) > br_age)) begin
          flushed[i] = 1'b1;
        end
      end
    end

    // Ascending port order lets the higher index win on a shared tag
    for (int p = 0; p < int'(NUM_WB); p++) begin
      if (wb_valid[p] && valid_q[wb_tag[p]] && !flushed[wb_tag[p]]) begin
        ready_d[wb_tag[p]] = 1'b1;
        data_d[wb_tag[p]]  = wb_data[p];
      end
    end

    for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
      if (CW'(k) < n_deq) begin
        valid_d[front_q + TW'(k)] = 1'b0;
        ready_d[front_q + TW'(k)] = 1'b0;
      end
    end

    valid_d = valid_d & ~flushed;
    ready_d = ready_d & ~flushed;

    if (enq_ok) begin
      valid_d[rear_q] = 1'b1;
      ready_d[rear_q] = 1'b0;
      data_d[rear_q]  = '0;
      pci_d[rear_q]   = enq_pci;
      rear_d          = rear_q + TW'(1);
    end

    if (br_mispredict) begin
      rear_d  = br_tag + TW'(1);
      count_d = CW'(br_age) + CW'(1) - n_deq;
    end else begin
      count_d = count_q + CW'(enq_ok) - n_deq;
    end

    front_d = front_q + TW'(n_deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
      for (int i = 0; i < int'(size); i++) begin
        data_q[i] <= '0;
        pci_q[i]  <= '0;
      end
    end else begin
      front_q <= front_d;
      rear_q  <= rear_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      for (int i = 0; i < int'(size); i++) begin
        data_q[i] <= data_d[i];
        pci_q[i]  <= pci_d[i];
      end
    end
  end

  assign enq_tag   = rear_q;
  assign front_tag = front_q;
  assign full      = (count_q == CW'(size));
  assign empty     = (count_q == '0);
  assign commit    = (n_deq != '0);
  assign num_deq   = int'(n_deq);

  always_comb begin
    for (int i = 0; i < int'(size); i++) begin
      rdest[i].rdy     = valid_q[i] & ready_q[i];
      rdest[i].pc_info = pci_q[i];
      rdest[i].data    = data_q[i];
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: per-cycle vector table with hand-computed
// expectations, plus hand sequences for port conflicts and mid-run reset.
module tb_rob_commit;
  import rob_commit_pkg::*;

  localparam int unsigned SZ = 8;
  localparam int unsigned NW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq;
  pci_t        enq_pci;
  logic [2:0]  enq_tag;
  logic        full;
  logic        empty;
  logic [NW-1:0] wb_valid;
  logic [2:0]  wb_tag [NW];
  logic [31:0] wb_data [NW];
  logic        br_mispredict;
  logic [2:0]  br_tag;
  logic        commit;
  int          num_deq;
  logic [2:0]  front_tag;
  sal2_t       rdest [SZ];

  int n_cmp = 0;
  int n_bad = 0;
  int seq_n = 0;

  always #5 clk = ~clk;

  rob_commit #(.size(SZ), .COMMIT_WIDTH(4), .NUM_WB(NW)) dut (
    .clk(clk), .rst(rst), .enq(enq), .enq_pci(enq_pci), .enq_tag(enq_tag),
    .full(full), .empty(empty), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_data(wb_data), .br_mispredict(br_mispredict), .br_tag(br_tag),
    .commit(commit), .num_deq(num_deq), .front_tag(front_tag), .rdest(rdest)
  );

  typedef struct {
    logic        enq;
    logic        wv0;
    logic [2:0]  wt0;
    logic [31:0] wd0;
    logic        wv1;
    logic [2:0]  wt1;
    logic [31:0] wd1;
    logic        br;
    logic [2:0]  bt;
    logic        e_full;
    logic        e_empty;
    int          e_nd;
    logic [2:0]  e_ft;
    logic [2:0]  e_et;
    logic        cchk;
    logic [2:0]  ctag;
    logic        crdy;
    logic [31:0] cdata;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t row(input logic e, input logic v0, input int t0, input int d0,
                               input logic v1, input int t1, input int d1,
                               input logic f, input logic em, input int nd,
                               input int ft, input int et);
    vec_t r;
    r.enq = e;  r.wv0 = v0; r.wt0 = 3'(t0); r.wd0 = 32'(d0);
    r.wv1 = v1; r.wt1 = 3'(t1); r.wd1 = 32'(d1);
    r.br = 1'b0; r.bt = 3'd0;
    r.e_full = f; r.e_empty = em; r.e_nd = nd; r.e_ft = 3'(ft); r.e_et = 3'(et);
    r.cchk = 1'b0; r.ctag = 3'd0; r.crdy = 1'b0; r.cdata = 32'd0;
    return r;
  endfunction

  task automatic add_chk(input int tag, input logic rdy, input int data);
    int last;
    last = tbl.size() - 1;
    tbl[last].cchk  = 1'b1;
    tbl[last].ctag  = 3'(tag);
    tbl[last].crdy  = rdy;
    tbl[last].cdata = 32'(data);
  endtask

  function automatic pci_t mkpci(input int n);
    pci_t p;
    p        = '0;
    p.pc     = 32'h1000 + 32'(n) * 32'd4;
    p.opcode = 7'h13;
    p.rd     = 5'(n);
    p.rs1    = 5'(n + 1);
    p.imm    = 32'(n);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enq = 1'b0; enq_pci = '0; wb_valid = '0; br_mispredict = 1'b0; br_tag = 3'd0;
    for (int p = 0; p < int'(NW); p++) begin
      wb_tag[p] = 3'd0; wb_data[p] = 32'd0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_enq(input int rd);
    enq = 1'b1;
    enq_pci = mkpci(seq_n);
    enq_pci.rd = 5'(rd);
    seq_n++;
  endtask

  initial begin
    logic any_rdy;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst full", full, 0);
    chk("rst empty", empty, 1);
    chk("rst commit", commit, 0);
    chk("rst num_deq", 64'(num_deq), 0);
    chk("rst enq_tag", enq_tag, 0);
    chk("rst front_tag", front_tag, 0);
    any_rdy = 1'b0;
    for (int i = 0; i < int'(SZ); i++) any_rdy = any_rdy | (rdest[i] != '0);
    chk("rst rdest zero", any_rdy, 0);

    // In-order retire: wb tags 2,0,1
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,1,0,0,0));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,0,1));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,0,2));
    tbl.push_back(row(0, 1,2,'h11,  0,0,0,     0,0,0,0,3));
    tbl.push_back(row(0, 1,0,'h22,  0,0,0,     0,0,0,0,3));
    tbl.push_back(row(0, 1,1,'h33,  0,0,0,     0,0,1,0,3)); add_chk(0, 1, 'h22);
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,0,2,1,3)); add_chk(2, 1, 'h11);
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,1,0,3,3)); add_chk(0, 0, 'h22);
    // Fill to 8, 9th refused, reverse writebacks, retire 4 + 4
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,1,0,3,3));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,4));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,5));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,6));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,7));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,0));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,1));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,2));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     1,0,0,3,3));
    tbl.push_back(row(0, 1,1,'h101, 1,2,'h102, 1,0,0,3,3));
    tbl.push_back(row(0, 1,7,'h107, 1,0,'h100, 1,0,0,3,3));
    tbl.push_back(row(0, 1,5,'h105, 1,6,'h106, 1,0,0,3,3));
    tbl.push_back(row(0, 1,3,'h103, 1,4,'h104, 1,0,0,3,3));
    tbl.push_back(row(0, 0,0,0,     0,0,0,     1,0,4,3,3)); add_chk(3, 1, 'h103);
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,0,4,7,3)); add_chk(7, 1, 'h107);
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,1,0,3,3)); add_chk(5, 0, 'h105);
    // Advance front to 6, then wrap 6,7,0,1
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,1,0,3,3));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,4));
    tbl.push_back(row(1, 1,3,'h203, 1,4,'h204, 0,0,0,3,5));
    tbl.push_back(row(0, 1,5,'h205, 0,0,0,     0,0,2,3,6));
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,0,1,5,6));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,1,0,6,6));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,6,7));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,6,0));
    tbl.push_back(row(1, 1,7,'h307, 1,0,'h300, 0,0,0,6,1));
    tbl.push_back(row(0, 1,6,'h306, 1,1,'h301, 0,0,0,6,2));
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,0,4,6,2)); add_chk(1, 1, 'h301);
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,1,0,2,2));
    // Build tags 3..7 with front 3, then flush younger than tag 4
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,1,0,2,2));
    tbl.push_back(row(1, 1,2,'h402, 0,0,0,     0,0,0,2,3));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,1,2,4));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,5));
    tbl.push_back(row(1, 0,0,0,     0,0,0,     0,0,0,3,6));
    tbl.push_back(row(1, 1,4,'h444, 0,0,0,     0,0,0,3,7));
    tbl.push_back(row(1, 1,6,'h666, 0,0,0,     0,0,0,3,0));
    tbl[tbl.size()-1].br = 1'b1;
    tbl[tbl.size()-1].bt = 3'd4;
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,0,0,3,5)); add_chk(6, 0, 0);
    tbl.push_back(row(0, 1,3,'h433, 0,0,0,     0,0,0,3,5)); add_chk(5, 0, 0);
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,0,2,3,5)); add_chk(4, 1, 'h444);
    tbl.push_back(row(0, 0,0,0,     0,0,0,     0,1,0,5,5));

    for (int i = 0; i < tbl.size(); i++) begin
      idle_inputs();
      if (tbl[i].enq) drive_enq(seq_n);
      wb_valid      = {tbl[i].wv1, tbl[i].wv0};
      wb_tag[0]     = tbl[i].wt0;  wb_data[0] = tbl[i].wd0;
      wb_tag[1]     = tbl[i].wt1;  wb_data[1] = tbl[i].wd1;
      br_mispredict = tbl[i].br;
      br_tag        = tbl[i].bt;
      chk($sformatf("row%0d full", i), full, tbl[i].e_full);
      chk($sformatf("row%0d empty", i), empty, tbl[i].e_empty);
      chk($sformatf("row%0d num_deq", i), 64'(num_deq), 64'(tbl[i].e_nd));
      chk($sformatf("row%0d commit", i), commit, (tbl[i].e_nd != 0));
      chk($sformatf("row%0d front_tag", i), front_tag, tbl[i].e_ft);
      chk($sformatf("row%0d enq_tag", i), enq_tag, tbl[i].e_et);
      if (tbl[i].cchk) begin
        chk($sformatf("row%0d rdy[%0d]", i, tbl[i].ctag), rdest[tbl[i].ctag].rdy, tbl[i].crdy);
        chk($sformatf("row%0d data[%0d]", i, tbl[i].ctag), rdest[tbl[i].ctag].data, tbl[i].cdata);
      end
      tick();
    end

    // Same-tag writeback conflict and writeback to an invalid tag
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      drive_enq(10 + i);
      tick();
    end
    idle_inputs();
    wb_valid = 2'b11;
    wb_tag[0] = 3'd2; wb_data[0] = 32'hA;
    wb_tag[1] = 3'd2; wb_data[1] = 32'hB;
    tick();
    idle_inputs();
    wb_valid = 2'b01;
    wb_tag[0] = 3'd5; wb_data[0] = 32'h55;
    tick();
    idle_inputs();
    chk("conflict data[2]", rdest[2].data, 32'hB);
    chk("conflict rdy[2]", rdest[2].rdy, 1);
    chk("stale rdy[5]", rdest[5].rdy, 0);
    chk("stale data[5]", rdest[5].data, 0);
    chk("pci rd[1]", rdest[1].pc_info.rd, 11);
    chk("head not ready", 64'(num_deq), 0);

    // Reset while 5 entries are valid and 2 are about to retire
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      drive_enq(i + 1);
      if (i == 4) begin
        wb_valid = 2'b11;
        wb_tag[0] = 3'd0; wb_data[0] = 32'h70;
        wb_tag[1] = 3'd1; wb_data[1] = 32'h71;
      end
      tick();
    end
    idle_inputs();
    chk("pre-rst num_deq", 64'(num_deq), 2);
    chk("pre-rst enq_tag", enq_tag, 5);
    rst = 1'b1;
    enq = 1'b1;
    enq_pci = mkpci(99);
    tick();
    rst = 1'b0;
    idle_inputs();
    chk("post-rst empty", empty, 1);
    chk("post-rst commit", commit, 0);
    chk("post-rst front_tag", front_tag, 0);
    chk("post-rst enq_tag", enq_tag, 0);
    any_rdy = 1'b0;
    for (int i = 0; i < int'(SZ); i++) any_rdy = any_rdy | rdest[i].rdy;
    chk("post-rst any rdy", any_rdy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer with in-order, multi-entry commit. Sits between dispatch/functional-unit writeback and the architectural register file: allocates one entry per dispatched instruction and captures results by tag. It retires up to `COMMIT_WIDTH` consecutive ready entries per cycle from the head. Its `commit`, `num_deq`, `front_tag` and `rdest` outputs drive the regfile write port and the commit-checking software model.

## Interface
- `size`, 8 — entry count; power of two; tags are `$clog2(size)` bits.
- `COMMIT_WIDTH`, 4 — maximum entries retired per cycle (1..size).
- `NUM_WB`, 2 — number of independent writeback ports.

- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `enq` in 1 — dispatch request; accepted only when `full`=0 and `flush`=0.
- `enq_pci` in pci_t — instruction info (pc, opcode, rd, rs1/rs2, immediates).
- `enq_tag` out $clog2(size) — tag the next accepted enqueue receives (= rear pointer).
- `full` out 1 — count == size.
- `empty` out 1 — count == 0.
- `wb_valid` in [NUM_WB] — result valid per port.
- `wb_tag` in [NUM_WB] × $clog2(size) — entry tag per port.
- `wb_data` in [NUM_WB] × 32 — result value per port.
- `br_mispredict` in 1 — flush every entry younger than `br_tag`.
- `br_tag` in $clog2(size) — tag of the mispredicted branch; must name a valid entry.
- `commit` out 1 — `num_deq` != 0.
- `num_deq` out int — entries retired at the coming edge (0..COMMIT_WIDTH).
- `front_tag` out $clog2(size) — head pointer.
- `rdest` out sal2_t [size] — entry array. `rdy` = valid & ready; also carries `pc_info` and `data`.

## Operation
- State: `front`, `rear`, `count` ($clog2(size)+1 bits). Per entry: `valid`, `ready`, `data[31:0]`, `pc_info`.
- Enqueue: on an accepted `enq`, entry[rear] ← {valid=1, ready=0, data=0, pc_info=enq_pci}; rear ← rear+1 mod size.
- Writeback: per port, if `wb_valid` and entry[wb_tag] is valid, set ready=1 and data=wb_data.
  - Writebacks to invalid entries are dropped.
  - If two ports hit the same tag, the higher port index wins.
- Commit selection (combinational from registered state):
  - `num_deq` = number of leading consecutive entries from `front` with valid&ready.
  - Capped by `COMMIT_WIDTH` and by `count`; stops at the first not-ready entry.
  - At the edge, each retired entry has valid ← 0, and front ← front + num_deq mod size.
- Flush (`br_mispredict`=1):
  - Invalidate every valid entry strictly younger than `br_tag`, i.e. ages (br_tag − front mod size) + 1 .. count−1.
  - rear ← br_tag+1 mod size.
  - Enqueue and writebacks to flushed tags are ignored that cycle.
  - Commit of older entries proceeds normally in the same cycle.
- Count update: count_next = (flush ? age(br_tag)+1 : count + enq_accepted) − num_deq.
- `rdest[i].data` of a retired entry keeps its last value; only `valid` clears.
- Wrap-around: all pointer arithmetic is mod size; age = (tag − front) mod size.

## Timing
- Reset values:
  - Pointers and count are 0; all valid/ready are 0.
  - `full`=0, `empty`=1, `commit`=0, `num_deq`=0, `enq_tag`=0, `front_tag`=0.
  - `rdest` is all zero.
- Reset asserted mid-operation discards all entries at that edge; reset has priority over enq/wb/flush.
- Pipeline latency:
  - Enqueue at edge N.
  - Earliest writeback is sampled at edge N+1.
  - `commit`=1 during cycle N+1..N+2, and the entry retires at edge N+2.
- Minimum enqueue-to-retire is 2 edges.
- Writeback in the same cycle as that entry's enqueue is illegal; the bench must not drive it.
- All outputs are registered state or combinational from registered state only. No input-to-output combinational path except none; `full` does not depend on same-cycle commit.
- When full and committing in the same cycle, `enq` is still refused. A slot freed at edge N is usable from cycle N+1.
- Downstream samples `rdest`, `num_deq` and `front_tag` before the retiring edge. The regfile writes rd ≠ 0 entries at that edge.

## Test plan
- Reset, then enqueue 3 addi ops (tags 0,1,2). Writeback tags 2,0,1 in successive cycles with data 0x11,0x22,0x33.
  - Required: `num_deq`=1 (tag 0) in the cycle after its writeback, then `num_deq`=2 (tags 1,2). `front_tag` 0→1→3.
- Fill 8 entries: `full`=1 and a 9th `enq` is ignored. Write back all 8 in one cycle per two tags.
  - Required: retires 4 then 4 (COMMIT_WIDTH cap). `empty`=1 afterwards.
- Wrap-around: advance front to 6, then enqueue 4 entries (tags 6,7,0,1). Write back all.
  - Required: `num_deq`=4 with `front_tag`=6, then front=2, count=0.
- Flush: entries at tags 3..7 with front=3, `br_mispredict` with `br_tag`=4, plus simultaneous `enq` and wb to tag 6.
  - Required: tags 5..7 become invalid, `enq` is refused, rear=5, count=2, `enq_tag`=5.
- Writeback conflict and stale tag: ports 0 and 1 both write tag 2 with 0xA and 0xB → data=0xB.
  - A writeback to an invalid tag 5 leaves entry 5 unchanged.
- Assert `rst` while 5 entries are valid and 2 are committing.
  - Required: the next cycle shows `empty`=1, `commit`=0, and all `rdest.rdy`=0.
